// File: rtl/ahb_ram_ctrl.sv
// ahb_ram_ctrl
// ------------------------------------------------------------------------------
// AHB-Lite slave front end for the on-chip RAM. It drives four 8-bit simple
// dual-port byte lanes. Each lane has one write port and one registered read
// port with 1-cycle latency, and it returns old data when a read and a write hit
// the same word.
//
// Bus handshake: a transfer is accepted on a rising edge when
// HSEL & HTRANS[1] & HREADY. Its data phase is the following cycle. The slave
// inserts a wait state (HREADYOUT=0) only in the first cycle of an ERROR
// response. Reads and writes are otherwise zero-wait.
//
// Ports:
//   HCLK, HRESETn      clock, synchronous active-low reset
//   HSEL, HADDR,       AHB-Lite address-phase inputs
//   HTRANS, HWRITE,
//   HSIZE, HREADY
//   HWDATA             write data (data phase)
//   HRDATA             read data (data phase)
//   HREADYOUT, HRESP   slave ready / response (0=OKAY, 1=ERROR)
//   ram_raddr          read word address, common to all lanes
//   ram_waddr          write word address, common to all lanes
//   ram_wdata          write data, lane n uses [8n+7:8n]
//   ram_we             per-lane write enable
//   ram_q              registered RAM read data
// ------------------------------------------------------------------------------
module ahb_ram_ctrl #(
   parameter int RAM_ADDR_WIDTH = 6
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      HSEL,
   input  logic [31:0]               HADDR,
   input  logic [1:0]                HTRANS,
   input  logic                      HWRITE,
   input  logic [2:0]                HSIZE,
   input  logic                      HREADY,
   input  logic [31:0]               HWDATA,
   output logic [31:0]               HRDATA,
   output logic                      HREADYOUT,
   output logic                      HRESP,
   output logic [RAM_ADDR_WIDTH-1:0] ram_raddr,
   output logic [RAM_ADDR_WIDTH-1:0] ram_waddr,
   output logic [31:0]               ram_wdata,
   output logic [3:0]                ram_we,
   input  logic [31:0]               ram_q
);

   localparam logic [1:0] ST_OKAY = 2'd0;
   localparam logic [1:0] ST_ERR1 = 2'd1;
   localparam logic [1:0] ST_ERR2 = 2'd2;

   logic [1:0]                state;
   logic [1:0]                state_nxt;
   logic                      accept;
   logic                      illegal;
   logic                      legal_wr;
   logic                      legal_rd;
   logic                      err_acc;
   logic                      fwd_hit;
   logic [3:0]                lane_mask;
   logic [RAM_ADDR_WIDTH-1:0] haddr_word;
   logic [RAM_ADDR_WIDTH-1:0] wr_addr;
   logic [3:0]                wr_mask;
   logic                      wr_pend;
   logic [3:0]                fwd_mask;
   logic [31:0]               fwd_data;

   // Upper address bits are ignored, so addresses wrap modulo the RAM size.
   // HTRANS[0] only separates NONSEQ from SEQ, and both are treated alike.
   logic unused_bits;
   assign unused_bits = ^{HADDR[31:RAM_ADDR_WIDTH+2], HTRANS[0]};

   assign haddr_word = HADDR[RAM_ADDR_WIDTH+1:2];
   assign accept     = HSEL & HTRANS[1] & HREADY;

   // Lane mask and alignment check from size and low address bits.
   always_comb begin
      lane_mask = 4'b0000;
      illegal   = 1'b0;
      case (HSIZE)
         3'd0: lane_mask = 4'b0001 << HADDR[1:0];
         3'd1: begin
            lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            illegal   = HADDR[0];
         end
         3'd2: begin
            lane_mask = 4'b1111;
            illegal   = |HADDR[1:0];
         end
         default: illegal = 1'b1;
      endcase
   end

   assign legal_wr = accept & ~illegal & HWRITE;
   assign legal_rd = accept & ~illegal & ~HWRITE;
   assign err_acc  = accept & illegal;

   // A read whose address phase overlaps a write data phase to the same word
   // gets old data from the RAM. The written bytes are captured here and merged
   // into HRDATA in the read data phase.
   assign fwd_hit = legal_rd & wr_pend & (wr_addr == haddr_word);

   always_comb begin
      state_nxt = ST_OKAY;
      case (state)
         ST_OKAY, ST_ERR2: state_nxt = err_acc ? ST_ERR1 : ST_OKAY;
         ST_ERR1:          state_nxt = ST_ERR2;
         default:          state_nxt = ST_OKAY;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state    <= ST_OKAY;
         wr_pend  <= 1'b0;
         wr_addr  <= '0;
         wr_mask  <= 4'b0000;
         fwd_mask <= 4'b0000;
         fwd_data <= 32'h0;
      end else begin
         state   <= state_nxt;
         wr_pend <= legal_wr;
         if (legal_wr) begin
            wr_addr <= haddr_word;
            wr_mask <= lane_mask;
         end
         if (fwd_hit) begin
            fwd_mask <= wr_mask;
            fwd_data <= HWDATA;
         end else begin
            fwd_mask <= 4'b0000;
         end
      end
   end

   assign HREADYOUT = (state != ST_ERR1);
   assign HRESP     = (state != ST_OKAY);

   // Reset drops a write that is in its data phase, even before the edge.
   assign ram_we    = wr_mask & {4{wr_pend & HRESETn}};
   assign ram_waddr = wr_addr;
   assign ram_wdata = HWDATA;
   assign ram_raddr = haddr_word;

   always_comb begin
      HRDATA = ram_q;
      for (int n = 0; n < 4; n++) begin
         if (fwd_mask[n]) HRDATA[8*n +: 8] = fwd_data[8*n +: 8];
      end
   end

endmodule
